// File: rtl/lisp_uart_regs.sv
`default_nettype none
// ==========================================================================
// lisp_uart_regs : 8N1 UART peripheral on the lisp_core hardware-register bus
// Revision 1.0
// ==========================================================================
module lisp_uart_regs #(
  parameter int CLKS_PER_BIT  = 16,
  parameter int RX_FIFO_DEPTH = 4,
  parameter int BASE_INDEX    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int PTR_W = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(RX_FIFO_DEPTH);
  localparam logic [15:0] DIV_RESET = 16'(CLKS_PER_BIT);

  localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
  localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3,
                         RX_WAIT = 3'd4;

  logic [6:0] offset;
  logic [1:0] sel;
  logic       mapped, rd_en, wr_en;

  logic [15:0] rdata_q, rdata_d, divisor_q, divisor_d;
  logic        overrun_q, overrun_d, frame_err_q, frame_err_d;

  logic [1:0]  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d, hold_q, hold_d;
  logic        hold_full_q, hold_full_d, tx_out_q, tx_out_d, tx_load, tx_tick;

  logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic [2:0]  rx_state_q, rx_state_d, rx_bit_q, rx_bit_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_push, frame_err_set;

  logic [7:0]       mem_q [RX_FIFO_DEPTH];
  logic [7:0]       mem_d [RX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       fifo_head;
  logic             pop, push_ok, overrun_set, status_clr;
  logic [15:0]      status;

  assign offset = register_index - 7'(BASE_INDEX);
  assign sel    = offset[1:0];
  assign mapped = offset < 7'd4;
  assign rd_en  = register_read & ~register_write & mapped;
  assign wr_en  = register_write & mapped;

  assign fifo_head = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign status    = {12'h000, frame_err_q, overrun_q, (count_q != '0), ~hold_full_q};
  assign status_clr = rd_en & (sel == 2'd0);

  always_comb begin
    rdata_d     = rdata_q;
    divisor_d   = divisor_q;
    if (rd_en) begin
      case (sel)
        2'd0:    rdata_d = status;
        2'd2:    rdata_d = {8'h00, fifo_head};
        2'd3:    rdata_d = divisor_q;
        default: rdata_d = rdata_q;
      endcase
    end
    if (wr_en && sel == 2'd3)
      divisor_d = (register_write_value < 16'd2) ? 16'd2 : register_write_value;
    // A new error arriving on the clearing read must survive it.
    overrun_d   = (overrun_q & ~status_clr) | overrun_set;
    frame_err_d = (frame_err_q & ~status_clr) | frame_err_set;
  end

  assign tx_tick = (tx_cnt_q == tx_div_q - 16'd1);

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_div_d    = tx_div_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_out_d    = tx_out_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_load     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_out_d = 1'b1;
        tx_load  = hold_full_q;
      end
      TX_START: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_tick) begin
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          tx_out_d   = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_tick) begin
          tx_cnt_d = 16'd0;
          if (tx_bit_q == 3'd7) begin
            tx_out_d   = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_out_d   = tx_shift_q[1];
          end
        end
      end
      default: begin
        tx_cnt_d = tx_cnt_q + 16'd1;
        if (tx_tick) begin
          tx_cnt_d   = 16'd0;
          tx_state_d = TX_IDLE;
          tx_load    = hold_full_q;
        end
      end
    endcase
    if (tx_load) begin
      tx_state_d  = TX_START;
      tx_shift_d  = hold_q;
      tx_cnt_d    = 16'd0;
      tx_div_d    = divisor_q;
      tx_out_d    = 1'b0;
      hold_full_d = 1'b0;
    end
    if (wr_en && sel == 2'd1 && !hold_full_q) begin
      hold_d      = register_write_value[7:0];
      hold_full_d = 1'b1;
    end
  end

  assign rx_half = rx_div_q >> 1;

  always_comb begin
    rx_s1_d       = uart_rx;
    rx_s2_d       = rx_s1_q;
    rx_prev_d     = rx_s2_q;
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_div_d      = rx_div_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = 16'd0;
          rx_div_d   = divisor_q;
        end
      end
      RX_START: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_cnt_q == rx_half - 16'd1) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d   = 16'd0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_d = rx_cnt_q + 16'd1;
        if (rx_cnt_q == rx_div_q - 16'd1) begin
          rx_cnt_d      = 16'd0;
          rx_push       = rx_s2_q;
          frame_err_set = ~rx_s2_q;
          rx_state_d    = rx_s2_q ? RX_IDLE : RX_WAIT;
        end
      end
      default: begin
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop         = rd_en & (sel == 2'd2) & (count_q != '0);
    push_ok     = rx_push & (count_q != FIFO_FULL);
    overrun_set = rx_push & (count_q == FIFO_FULL);
    if (push_ok) begin
      mem_d[wr_ptr_q] = rx_shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q     <= 16'h0000;
      divisor_q   <= DIV_RESET;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= 16'd0;
      tx_div_q    <= DIV_RESET;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      tx_out_q    <= 1'b1;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= 16'd0;
      rx_div_q    <= DIV_RESET;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      mem_q       <= '{default: 8'h00};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      rdata_q     <= rdata_d;
      divisor_q   <= divisor_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_div_q    <= tx_div_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_out_q    <= tx_out_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_div_q    <= rx_div_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign register_read_value = rdata_q;
  assign uart_tx             = tx_out_q;

endmodule
`default_nettype wire

// File: tb/tb_lisp_uart_regs.sv
`default_nettype none
// ==========================================================================
// tb_lisp_uart_regs : directed self-checking bench for lisp_uart_regs
// Revision 1.0
// ==========================================================================
`timescale 1ns/1ps
module tb_lisp_uart_regs;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value;
  logic        uart_tx;
  logic        uart_rx;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  lisp_uart_regs #(.CLKS_PER_BIT(16), .RX_FIFO_DEPTH(4), .BASE_INDEX(0)) dut (
    .clk                  (clk),
    .reset                (reset),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .uart_tx              (uart_tx),
    .uart_rx              (uart_rx)
  );

  task automatic reg_read(input logic [6:0] idx, output logic [15:0] data);
    @(negedge clk);
    register_index = idx; register_read = 1'b1; register_write = 1'b0;
    @(negedge clk);
    register_read = 1'b0;
    data = register_read_value;
  endtask

  task automatic reg_write(input logic [6:0] idx, input logic [15:0] val);
    @(negedge clk);
    register_index = idx; register_read = 1'b1; register_write = 1'b1;
    register_write_value = val;
    @(negedge clk);
    register_read = 1'b0; register_write = 1'b0;
  endtask

  // Each frame bit held for 4 clocks (divisor 4); f[0] is the start bit.
  task automatic send_frame(input logic [9:0] f);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); uart_rx = f[i];
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic idle_rx(input int n);
    repeat (n) begin @(negedge clk); uart_rx = 1'b1; end
  endtask

  task automatic test_reset;
    logic [15:0] v;
    reset = 1'b1; register_index = 7'd0; register_read = 1'b0; register_write = 1'b0;
    register_write_value = 16'h0000; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", uart_tx); end
    total++; if (register_read_value !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h want=0000", register_read_value); end
    reset = 1'b0;
    reg_read(7'd0, v);
    total++; if (v !== 16'h0001) begin bad++; $display("FAIL reset_status got=%h want=0001", v); end
    reg_read(7'd3, v);
    total++; if (v !== 16'h0010) begin bad++; $display("FAIL reset_divisor got=%h want=0010", v); end
  endtask

  task automatic test_tx;
    logic [19:0] stream;
    logic        exp;
    stream = {10'h278, 10'h34A};  // frame 8'h3C after frame 8'hA5
    reg_write(7'd3, 16'd4);
    @(negedge clk);
    register_index = 7'd1; register_write = 1'b1; register_read = 1'b1;
    register_write_value = 16'h00A5;
    for (int n = 0; n <= 84; n++) begin
      @(negedge clk);
      register_write = 1'b0; register_read = 1'b0;
      exp = (n == 0 || n > 80) ? 1'b1 : stream[(n-1)/4];
      total++; if (uart_tx !== exp) begin bad++; $display("FAIL tx_wave n=%0d got=%b want=%b", n, uart_tx, exp); end
      if (n == 1) begin
        total++; if (register_read_value !== 16'h0000) begin bad++; $display("FAIL tx_ready_low got=%h want=0000", register_read_value); end
      end
      if (n == 2) begin
        total++; if (register_read_value !== 16'h0001) begin bad++; $display("FAIL tx_ready_back got=%h want=0001", register_read_value); end
      end
      if (n == 13) begin
        total++; if (register_read_value !== 16'h0000) begin bad++; $display("FAIL tx_holding_full got=%h want=0000", register_read_value); end
      end
      case (n)
        0, 1, 12: begin register_index = 7'd0; register_read = 1'b1; end
        5: begin
          register_index = 7'd1; register_write = 1'b1; register_read = 1'b1;
          register_write_value = 16'h003C;
        end
        10: begin
          register_index = 7'd1; register_write = 1'b1; register_read = 1'b1;
          register_write_value = 16'h00FF;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_rx_basic;
    logic [15:0] v;
    send_frame({1'b1, 8'h3C, 1'b0});
    idle_rx(6);
    reg_read(7'd0, v);
    total++; if (v !== 16'h0003) begin bad++; $display("FAIL rx_status_avail got=%h want=0003", v); end
    reg_read(7'd2, v);
    total++; if (v !== 16'h003C) begin bad++; $display("FAIL rx_data got=%h want=003C", v); end
    reg_read(7'd0, v);
    total++; if (v !== 16'h0001) begin bad++; $display("FAIL rx_status_empty got=%h want=0001", v); end
    reg_read(7'd2, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL rx_empty_read got=%h want=0000", v); end
  endtask

  task automatic test_rx_overrun;
    logic [15:0] v;
    logic [7:0]  bytes [5];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) send_frame({1'b1, bytes[i], 1'b0});
    idle_rx(6);
    reg_read(7'd0, v);
    total++; if (v !== 16'h0007) begin bad++; $display("FAIL ovr_status got=%h want=0007", v); end
    reg_read(7'd0, v);
    total++; if (v !== 16'h0003) begin bad++; $display("FAIL ovr_cleared got=%h want=0003", v); end
    for (int i = 0; i < 4; i++) begin
      reg_read(7'd2, v);
      total++; if (v !== {8'h00, bytes[i]}) begin bad++; $display("FAIL ovr_data%0d got=%h want=%h", i, v, {8'h00, bytes[i]}); end
    end
    reg_read(7'd0, v);
    total++; if (v !== 16'h0001) begin bad++; $display("FAIL ovr_drained got=%h want=0001", v); end
  endtask

  task automatic test_rx_errors;
    logic [15:0] v;
    send_frame({1'b0, 8'h5A, 1'b0});
    idle_rx(10);
    reg_read(7'd0, v);
    total++; if (v !== 16'h0009) begin bad++; $display("FAIL frame_err_status got=%h want=0009", v); end
    reg_read(7'd0, v);
    total++; if (v !== 16'h0001) begin bad++; $display("FAIL frame_err_clear got=%h want=0001", v); end
    @(negedge clk); uart_rx = 1'b0;
    @(negedge clk); uart_rx = 1'b1;
    idle_rx(20);
    reg_read(7'd0, v);
    total++; if (v !== 16'h0001) begin bad++; $display("FAIL glitch_status got=%h want=0001", v); end
    reg_read(7'd2, v);
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL glitch_data got=%h want=0000", v); end
  endtask

  task automatic test_divisor;
    logic [15:0] v;
    reg_write(7'd3, 16'd1);
    reg_read(7'd3, v);
    total++; if (v !== 16'h0002) begin bad++; $display("FAIL div_min1 got=%h want=0002", v); end
    reg_write(7'd3, 16'h1234);
    reg_read(7'd3, v);
    total++; if (v !== 16'h1234) begin bad++; $display("FAIL div_write got=%h want=1234", v); end
    reg_write(7'd0, 16'hFFFF);
    reg_write(7'd2, 16'hFFFF);
    reg_write(7'd7, 16'hFFFF);
    total++; if (register_read_value !== 16'h1234) begin bad++; $display("FAIL write_holds got=%h want=1234", register_read_value); end
    reg_read(7'd9, v);
    total++; if (v !== 16'h1234) begin bad++; $display("FAIL unmapped_holds got=%h want=1234", v); end
    reg_read(7'd0, v);
    total++; if (v !== 16'h0001) begin bad++; $display("FAIL status_write_ignored got=%h want=0001", v); end
    reg_read(7'd3, v);
    total++; if (v !== 16'h1234) begin bad++; $display("FAIL div_unchanged got=%h want=1234", v); end
    reg_write(7'd3, 16'd0);
    reg_read(7'd3, v);
    total++; if (v !== 16'h0002) begin bad++; $display("FAIL div_min0 got=%h want=0002", v); end
  endtask

  task automatic test_reset_mid_tx;
    logic [15:0] v;
    reg_write(7'd3, 16'd4);
    reg_write(7'd1, 16'h0000);
    repeat (3) @(negedge clk);
    total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL midtx_low got=%b want=0", uart_tx); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL midtx_reset got=%b want=1", uart_tx); end
    reset = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL midtx_stays_idle got=%b want=1", uart_tx); end
    reg_read(7'd0, v);
    total++; if (v !== 16'h0001) begin bad++; $display("FAIL midtx_status got=%h want=0001", v); end
    reg_read(7'd3, v);
    total++; if (v !== 16'h0010) begin bad++; $display("FAIL midtx_divisor got=%h want=0010", v); end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_basic();
    test_rx_overrun();
    test_rx_errors();
    test_divisor();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
